// File: rtl/multi_button_ctrl.sv
// multi_button_ctrl: N-channel button synchronizer, debouncer, edge detector and mode-driven light output
module multi_button_ctrl #(
   parameter int N_CH        = 4,
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CYCLES  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_CH-1:0]   button,
   input  logic [2*N_CH-1:0] mode,
   input  logic              clr,
   output logic [N_CH-1:0]   light,
   output logic [N_CH-1:0]   press_pulse,
   output logic [N_CH-1:0]   release_pulse,
   output logic [N_CH-1:0]   stable
);
   localparam int CW = $clog2(DEB_CYCLES + 1);
   logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
   logic [N_CH-1:0] synced, commit, stable_nxt, press_ev, rel_ev, light_nxt;
   logic [CW-1:0]   cnt     [N_CH];
   logic [CW-1:0]   cnt_nxt [N_CH];
   assign synced = sync_q[SYNC_STAGES-1];
   // plain flop chain per channel; nothing combinational ahead of the last stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], button};
   end
   // debounce qualification, edge events and per-channel light next state
   always_comb begin
      commit    = '0;
      light_nxt = '0;
      for (int i = 0; i < N_CH; i++) begin
         commit[i]  = (synced[i] != stable[i]) && (cnt[i] == CW'(DEB_CYCLES - 1));
         cnt_nxt[i] = (synced[i] != stable[i] && !commit[i]) ? cnt[i] + 1'b1 : '0;
      end
      stable_nxt = stable ^ commit;
      press_ev   = commit & stable_nxt;
      rel_ev     = commit & ~stable_nxt;
      for (int i = 0; i < N_CH; i++)
         light_nxt[i] = clr                    ? 1'b0 :
                        mode[2*i+:2] == 2'b01 ? stable_nxt[i] :
                        mode[2*i+:2] == 2'b10 ? light[i] ^ rel_ev[i] :
                        mode[2*i+:2] == 2'b11 ? press_ev[i] :
                                                light[i] ^ press_ev[i];
   end
   // debounced state, counters and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
         stable        <= '0;
         light         <= '0;
         press_pulse   <= '0;
         release_pulse <= '0;
      end else begin
         cnt           <= cnt_nxt;
         stable        <= stable_nxt;
         light         <= light_nxt;
         press_pulse   <= press_ev;
         release_pulse <= rel_ev;
      end
   end
endmodule
